uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Command sequencer that sits downstream of `uart_rx`. It consumes the received-byte strobe and data, and parses fixed 4-byte write packets. It updates a bank of four 8-bit configuration registers, which drive LEDs and other top-level settings. Malformed packets and stalled packets are rejected, and each rejection is reported with a one-cycle error pulse.

## Interface
- `TIMEOUT`, default 120000: inter-byte timeout in `clk` cycles (10 ms at 12 MHz). Must be ≥ 2. Counter width is sized to hold `TIMEOUT`.
- `clk`, input, 1: system clock.
- `rstn`, input, 1: reset, asynchronous, active-low.
- `rcv`, input, 1: byte-received strobe from `uart_rx`. Each cycle with `rcv`=1 is one byte.
- `data`, input, 8: received byte, valid when `rcv`=1.
- `reg0`, output, 8: configuration register 0 (LEDs use `reg0[3:0]`).
- `reg1`, output, 8: configuration register 1.
- `reg2`, output, 8: configuration register 2.
- `reg3`, output, 8: configuration register 3.
- `wr`, output, 1: one-cycle pulse when a register has been written.
- `err`, output, 1: one-cycle pulse when a packet is rejected (bad checksum, bad address or timeout).
- `busy`, output, 1: high while a packet is in progress (state ≠ IDLE).

## Operation
- Packet format: `0x57` ('W'), ADDR, DATA, CHK.
  - CHK = `0x57` ^ ADDR ^ DATA.
  - ADDR[7:2] must be 0. ADDR[1:0] selects `reg0`..`reg3`.
- States: IDLE, ADDR, DATA, CHK. All transitions occur on a `clk` edge.
  - IDLE: on `rcv` with `data`=`0x57`, go to ADDR. On `rcv` with any other byte, stay in IDLE silently (no `err`).
  - ADDR: on `rcv`, latch `data` into the address register and go to DATA.
  - DATA: on `rcv`, latch `data` into the data register and go to CHK.
  - CHK: on `rcv`, return to IDLE in every case.
    - If `data` equals the computed CHK and ADDR[7:2]=0: write DATA to the selected register and pulse `wr`.
    - Otherwise: pulse `err`. No register changes.
- `0x57` received in ADDR, DATA or CHK is handled as ordinary payload. It does not resynchronise the parser.
- Timeout:
  - The idle counter clears on every `rcv` and on entry to IDLE.
  - In ADDR, DATA or CHK, the counter increments on each cycle without `rcv`.
  - When the counter reaches `TIMEOUT`-1 with no `rcv`: go to IDLE and pulse `err`.
  - If `rcv` arrives in the same cycle the counter hits the limit, `rcv` wins: the byte is processed and there is no timeout.
- `wr` and `err` are never high in the same cycle.
- Back-to-back packets are supported with no gap. The first byte of a new packet may arrive in the cycle right after the CHK byte.

## Timing
- Reset (asynchronous, `rstn`=0):
  - state = IDLE, counter = 0.
  - `reg0`..`reg3` = `0x00`, `wr`=0, `err`=0, `busy`=0.
- Reset asserted mid-packet discards the partial packet immediately. No `err` is produced.
- All outputs are registered.
- Write latency: `rcv` with CHK is sampled on edge N. At edge N, the selected register takes its new value and `wr` goes high. `wr` stays high for exactly one cycle and is low again after edge N+1.
- `err` latency on a bad CHK or bad ADDR: same as `wr`, one cycle after the sampling edge.
- `err` on timeout: high for one cycle following the edge at which the counter reaches `TIMEOUT`-1. This is exactly `TIMEOUT` cycles after the last accepted byte's edge.
- `busy` rises on the edge that accepts `0x57` in IDLE. It falls on the edge that returns to IDLE.
- Registers hold their value indefinitely until the next valid write.

## Test plan
- Valid write: send `57 00 0A 5D`. Then `reg0`=`0x0A`, one `wr` pulse, no `err`, `busy` back to 0. `reg1`..`reg3` stay `0x00`.
- Bad checksum: send `57 02 33 00`. Then one `err` pulse, no `wr`, `reg2` unchanged at `0x00`.
- Bad address: send `57 04 11 42` (CHK correct for those bytes). Then one `err` pulse, no register changes.
- Timeout: send `57 01`, then hold `rcv` low, with `TIMEOUT`=16 in the bench. Then `err` pulses 16 cycles after the ADDR byte's edge, and the state is IDLE. A following `57 01 FF A9` then writes `reg1`=`0xFF`.
- Noise and back-to-back: send `00 41 57 03 80 D4` immediately followed by `57 00 05 52`. The leading `00` and `41` are ignored with no `err`. Then `reg3`=`0x80` and `reg0`=`0x05`, with two `wr` pulses and no `err`.
- Reset mid-packet: send `57 02 77`, then pulse `rstn` low. All registers read `0x00`, `busy`=0, and there is no `err` pulse. A following `57 02 77 22` writes `reg2`=`0x77`.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// Parses 'W',ADDR,DATA,CHK byte packets into four config registers; wr/err pulse one cycle after the CHK byte edge.
// No backpressure: every rcv strobe is consumed; a stalled packet is dropped after TIMEOUT idle cycles.
module uart_cmd_ctrl #(
  parameter int TIMEOUT = 120000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rcv,
  input  logic [7:0] data,
  output logic [7:0] reg0,
  output logic [7:0] reg1,
  output logic [7:0] reg2,
  output logic [7:0] reg3,
  output logic       wr,
  output logic       err,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_CHK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      dat_q, dat_d;
  logic [3:0][7:0] regs_q, regs_d;
  logic            wr_q, wr_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    regs_d  = regs_q;
    wr_d    = 1'b0;
    err_d   = 1'b0;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      if (rcv && data == 8'h57) state_d = ST_ADDR;
    end else if (rcv) begin
      // A byte arriving on the limit cycle is processed, not timed out.
      cnt_d = '0;
      case (state_q)
        ST_ADDR: begin
          addr_d  = data;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          dat_d   = data;
          state_d = ST_CHK;
        end
        default: begin
          state_d = ST_IDLE;
          if (data == (8'h57 ^ addr_q ^ dat_q) && addr_q[7:2] == 6'd0) begin
            regs_d[addr_q[1:0]] = dat_q;
            wr_d                = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      err_d   = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dat_q   <= '0;
      regs_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      regs_q  <= regs_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign reg0 = regs_q[0];
  assign reg1 = regs_q[1];
  assign reg2 = regs_q[2];
  assign reg3 = regs_q[3];
  assign wr   = wr_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: fixed vector table, hand sequences for timeout/reset, then random traffic vs a packet-level model.
module tb_uart_cmd_ctrl;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rcv;
  logic [7:0] data;
  logic [7:0] reg0, reg1, reg2, reg3;
  logic       wr, err, busy;

  uart_cmd_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .rcv(rcv), .data(data),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .wr(wr), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: bytes of the packet in flight plus idle gap length.
  logic [7:0] pkt[$];
  int         gap;
  logic [7:0] mreg[4];
  logic       mwr, merr;

  task automatic model_reset();
    pkt.delete();
    gap  = 0;
    mwr  = 1'b0;
    merr = 1'b0;
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
  endtask

  task automatic model_step(input logic r, input logic [7:0] d);
    mwr  = 1'b0;
    merr = 1'b0;
    if (r) begin
      gap = 0;
      if (pkt.size() == 0) begin
        if (d == 8'h57) pkt.push_back(d);
      end else begin
        pkt.push_back(d);
        if (pkt.size() == 4) begin
          if (d == (pkt[0] ^ pkt[1] ^ pkt[2]) && pkt[1] < 8'd4) begin
            mreg[pkt[1]] = pkt[2];
            mwr = 1'b1;
          end else begin
            merr = 1'b1;
          end
          pkt.delete();
        end
      end
    end else if (pkt.size() != 0) begin
      gap++;
      if (gap == TMO) begin
        merr = 1'b1;
        pkt.delete();
        gap = 0;
      end
    end
  endtask

  // Called at a negedge: drive, take one posedge, compare at the next negedge.
  task automatic step(input logic r, input logic [7:0] d);
    rcv  = r;
    data = d;
    @(posedge clk);
    model_step(r, d);
    @(negedge clk);
    chk("model_wr", wr, mwr);
    chk("model_err", err, merr);
    chk("model_busy", busy, pkt.size() != 0);
    chk("model_regs", {reg3, reg2, reg1, reg0}, {mreg[3], mreg[2], mreg[1], mreg[0]});
  endtask

  typedef struct {
    logic [7:0]  d;
    logic        ewr;
    logic        eerr;
    logic        ebusy;
    logic [31:0] eregs;
  } vec_t;
  vec_t vecs[$];

  task automatic addv(input logic [7:0] d, input logic w, input logic e, input logic b,
                      input logic [31:0] rg);
    vec_t v;
    v.d = d; v.ewr = w; v.eerr = e; v.ebusy = b; v.eregs = rg;
    vecs.push_back(v);
  endtask

  task automatic send(input logic [7:0] d, input int idle);
    step(1'b1, d);
    for (int i = 0; i < idle; i++) step(1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] a, dd, c;
    int         kind, n;

    // Valid write to reg0
    addv(8'h57, 0, 0, 1, 32'h0); addv(8'h00, 0, 0, 1, 32'h0);
    addv(8'h0A, 0, 0, 1, 32'h0); addv(8'h5D, 1, 0, 0, 32'h0000000A);
    // Bad checksum
    addv(8'h57, 0, 0, 1, 32'h0000000A); addv(8'h02, 0, 0, 1, 32'h0000000A);
    addv(8'h33, 0, 0, 1, 32'h0000000A); addv(8'h00, 0, 1, 0, 32'h0000000A);
    // Bad address with a correct checksum
    addv(8'h57, 0, 0, 1, 32'h0000000A); addv(8'h04, 0, 0, 1, 32'h0000000A);
    addv(8'h11, 0, 0, 1, 32'h0000000A); addv(8'h42, 0, 1, 0, 32'h0000000A);
    // Noise then back-to-back packets
    addv(8'h00, 0, 0, 0, 32'h0000000A); addv(8'h41, 0, 0, 0, 32'h0000000A);
    addv(8'h57, 0, 0, 1, 32'h0000000A); addv(8'h03, 0, 0, 1, 32'h0000000A);
    addv(8'h80, 0, 0, 1, 32'h0000000A); addv(8'hD4, 1, 0, 0, 32'h8000000A);
    addv(8'h57, 0, 0, 1, 32'h8000000A); addv(8'h00, 0, 0, 1, 32'h8000000A);
    addv(8'h05, 0, 0, 1, 32'h8000000A); addv(8'h52, 1, 0, 0, 32'h80000005);

    rstn = 1'b0;
    rcv  = 1'b0;
    data = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_regs", {reg3, reg2, reg1, reg0}, 32'h0);
    chk("reset_outs", {wr, err, busy}, 3'b000);
    rstn = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      step(1'b1, vecs[i].d);
      chk($sformatf("vec%0d_wr", i), wr, vecs[i].ewr);
      chk($sformatf("vec%0d_err", i), err, vecs[i].eerr);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].ebusy);
      chk($sformatf("vec%0d_regs", i), {reg3, reg2, reg1, reg0}, vecs[i].eregs);
    end

    // Timeout: err exactly TMO edges after the ADDR byte
    step(1'b1, 8'h57);
    step(1'b1, 8'h01);
    for (int k = 1; k <= TMO + 1; k++) begin
      step(1'b0, 8'h00);
      chk($sformatf("tmo_err_k%0d", k), err, k == TMO);
      chk($sformatf("tmo_busy_k%0d", k), busy, k < TMO);
    end
    send(8'h57, 0); send(8'h01, 0); send(8'hFF, 0); send(8'hA9, 0);
    chk("tmo_then_write_wr", wr, 1'b1);
    chk("tmo_then_write_reg1", reg1, 8'hFF);

    // Byte on the limit cycle wins over timeout
    send(8'h57, 0);
    send(8'h03, TMO - 1);
    step(1'b1, 8'h11);
    chk("limit_byte_err", err, 1'b0);
    chk("limit_byte_busy", busy, 1'b1);
    step(1'b1, 8'h45);
    chk("limit_byte_wr", wr, 1'b1);
    chk("limit_byte_reg3", reg3, 8'h11);

    // Reset mid-packet
    send(8'h57, 0); send(8'h02, 0); send(8'h77, 0);
    rstn = 1'b0;
    #1;
    chk("midrst_regs", {reg3, reg2, reg1, reg0}, 32'h0);
    chk("midrst_outs", {wr, err, busy}, 3'b000);
    model_reset();
    @(negedge clk);
    chk("midrst_hold_err", err, 1'b0);
    rstn = 1'b1;
    send(8'h57, 0); send(8'h02, 0); send(8'h77, 0); send(8'h22, 0);
    chk("midrst_after_wr", wr, 1'b1);
    chk("midrst_after_reg2", reg2, 8'h77);

    // Random traffic against the model
    for (int p = 0; p < 400; p++) begin
      kind = $urandom_range(0, 9);
      a    = 8'($urandom_range(0, 3));
      dd   = 8'($urandom);
      if (kind == 7) a = 8'($urandom_range(4, 255));
      c = 8'h57 ^ a ^ dd;
      if (kind == 6) c = c ^ 8'($urandom_range(1, 255));
      n = (kind == 9) ? $urandom_range(1, 3) : 4;
      if (kind == 8) begin
        send(8'($urandom), $urandom_range(0, 2));
      end else begin
        for (int b = 0; b < n; b++) begin
          send((b == 0) ? 8'h57 : (b == 1) ? a : (b == 2) ? dd : c,
               ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 3, TMO + 2)
                                           : $urandom_range(0, 2));
        end
      end
    end
    for (int i = 0; i < TMO + 4; i++) step(1'b0, 8'h00);
    chk("final_idle_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
